rib_rr_xbar: RTL and testbench
==============================

// Module: rib_rr_xbar
// PURPOSE
//   Parametrised successor of the SoC bus interconnect: NUM_M masters to NUM_S slaves.
//   Registered round-robin ownership with a bounded hold time replaces fixed priority.
//   Adds an unmapped-address error report.
//   Sits between rooth core / debug masters and inst_mem, data_mem, timer, uart, gpio and spi.
// PARAMETERS
//   NUM_M     4   number of masters (>=2)
//   NUM_S     6   number of slaves (<= 2**(SEL_MSB-SEL_LSB+1))
//   AW        32  address width
//   DW        32  data width
//   SEL_MSB   31  top address bit of the slave select field
//   SEL_LSB   28  bottom address bit of the slave select field
//   MAX_HOLD  16  max consecutive granted cycles while others wait; 0 = no preemption
//   FETCH_M   1   master index of the core fetch port; reset owner and hold_flag reference
// PORTS
//   clk          in   1         system clock
//   rst_n        in   1         synchronous active-low reset
//   m_addr_i     in   NUM_M*AW  master addresses, master k at [k*AW +: AW]
//   m_data_i     in   NUM_M*DW  master write data
//   m_data_o     out  NUM_M*DW  read data to masters
//   m_req_i      in   NUM_M     master request
//   m_we_i       in   NUM_M     master write enable
//   m_gnt_o      out  NUM_M     one-hot grant (all zero when no grant)
//   s_addr_o     out  NUM_S*AW  slave address, select field zeroed
//   s_data_o     out  NUM_S*DW  slave write data
//   s_data_i     in   NUM_S*DW  slave read data (combinational read)
//   s_we_o       out  NUM_S     slave write enable
//   hold_flag_o  out  1         m_req_i[FETCH_M] & ~m_gnt_o[FETCH_M]
//   err_o        out  1         registered one-cycle pulse: granted access hit unmapped slave
//   err_addr_o   out  AW        address of last unmapped access
// BEHAVIOUR
// - State: owner[$clog2(NUM_M)], own_vld, cnt (counts to MAX_HOLD), err_o, err_addr_o.
// - Reset values: owner=FETCH_M, own_vld=1, cnt=0, err_o=0, err_addr_o=0.
// - Cycle after reset: the fetch port can be granted immediately.
// - Grant (combinational): m_gnt_o[owner] = own_vld & m_req_i[owner]. Only one grant per cycle.
// - Routing, same cycle as grant:
//   - sel = m_addr_i[g][SEL_MSB:SEL_LSB] of the granted master g.
//   - If sel < NUM_S: s_we_o[sel] = m_we_i[g]; m_data_o[g] = s_data_i[sel].
//   - s_addr_o and s_data_o of every slave broadcast master g's address (select field zeroed) and write data.
//   - Non-granted masters get m_data_o = 0; all s_we_o = 0 when there is no grant.
// - Unmapped (sel >= NUM_S) with a grant:
//   - No s_we_o; m_data_o[g] = 0.
//   - Next cycle: err_o = 1 and err_addr_o = full address. err_o is 1 for one cycle per unmapped cycle.
// - Round-robin pick: the first requester searching (owner+1) mod NUM_M upward with wrap; the owner itself is last.
// - State transitions, evaluated each edge:
//   - OWNED, owner requesting, no preempt: cnt <= cnt+1 (saturating).
//   - OWNED, preempt: another master requesting and MAX_HOLD != 0 and cnt == MAX_HOLD-1.
//     Owner is granted this cycle; next cycle owner <= pick, cnt <= 0.
//   - OWNED, owner not requesting, another master requesting:
//     This cycle has no grant (one bubble); owner <= pick, cnt <= 0.
//   - OWNED, no request at all: own_vld <= 0, owner unchanged (remembered as the RR pointer).
//   - IDLE (own_vld=0), any request: own_vld <= 1, owner <= pick. One cycle of arbitration latency.
// - Simultaneous preempt and owner drop: the drop rule applies. A single requester is never preempted.
// - Reset mid-transfer: takes effect at the edge; outputs follow the reset state next cycle. No transfer is completed.
// TESTING
// - Release rst_n; only m1 reads 0x0000_0010 -> same cycle m_gnt_o=4'b0010, s_addr_o[0]=0x10, m_data_o[1]=s_data_i[0], hold=0.
// - m0 and m1 request constantly -> m1 granted 16 cycles, then m0 for 16 cycles; hold_flag_o=1 during m0 cycles; alternation repeats.
// - m0 owns and writes 0x1000_0004 / 0xA5A5_A5A5 -> s_we_o=6'b000010, s_addr_o[1]=0x4, s_data_o[1]=0xA5A5_A5A5.
// - m1 reads 0x7000_0000 -> s_we_o=0, m_data_o[1]=0; next cycle err_o=1, err_addr_o=0x7000_0000, then err_o=0.
// - m1 owner drops req while m2 and m3 request -> one cycle with m_gnt_o=0, then m2 granted.
// - rst_n low for one edge while m3 owns -> next cycle owner=m1, cnt=0, err_o=0; m3 is regranted only by round-robin.

Source files
------------

// File: rtl/rib_rr_xbar.sv
// NUM_M x NUM_S bus crossbar with registered round-robin ownership, bounded hold
// time, and a one-cycle error pulse for granted accesses to unmapped slaves.
module rib_rr_xbar #(
  parameter int NUM_M    = 4,
  parameter int NUM_S    = 6,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter int MAX_HOLD = 16,
  parameter int FETCH_M  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  output logic [NUM_M*DW-1:0] m_data_o,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  output logic [NUM_M-1:0]    m_gnt_o,
  output logic [NUM_S*AW-1:0] s_addr_o,
  output logic [NUM_S*DW-1:0] s_data_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  output logic [NUM_S-1:0]    s_we_o,
  output logic                hold_flag_o,
  output logic                err_o,
  output logic [AW-1:0]       err_addr_o
);

  localparam int OW = $clog2(NUM_M);
  localparam int SW = SEL_MSB - SEL_LSB + 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [OW-1:0] owner, owner_nxt, pick;
  logic          own_vld, own_vld_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner_req, others_req, gnt_any, sel_ok, preempt;
  logic [AW-1:0] g_addr, g_addr_z;
  logic [DW-1:0] g_data, rdata;
  logic          g_we;
  logic [SW-1:0] sel;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (int'(v) < MAX_HOLD) return v + CW'(1);
    return v;
  endfunction

  // Round-robin search starting just after the owner; the owner itself ranks last.
  always_comb begin
    int best;
    int d;
    pick = owner;
    best = NUM_M;
    d    = 0;
    for (int k = 0; k < NUM_M; k++) begin
      if (m_req_i[k]) begin
        d = (k + NUM_M - int'(owner) - 1) % NUM_M;
        if (d < best) begin
          best = d;
          pick = OW'(k);
        end
      end
    end
  end

  assign owner_req  = m_req_i[owner];
  assign others_req = |(m_req_i & ~(NUM_M'(1) << owner));
  assign gnt_any    = own_vld & owner_req;

  // Stage 0: combinational routing of the owning master to the slaves
  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_we   = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (owner == OW'(k)) begin
        g_addr = m_addr_i[k*AW +: AW];
        g_data = m_data_i[k*DW +: DW];
        g_we   = m_we_i[k];
      end
    end
  end

  assign sel    = g_addr[SEL_MSB:SEL_LSB];
  assign sel_ok = int'(sel) < NUM_S;

  always_comb begin
    g_addr_z                  = g_addr;
    g_addr_z[SEL_MSB:SEL_LSB] = '0;
    rdata    = '0;
    s_we_o   = '0;
    m_gnt_o  = '0;
    m_data_o = '0;
    for (int s = 0; s < NUM_S; s++) begin
      s_addr_o[s*AW +: AW] = g_addr_z;
      s_data_o[s*DW +: DW] = g_data;
      if (gnt_any && sel_ok && int'(sel) == s) begin
        s_we_o[s] = g_we;
        rdata     = s_data_i[s*DW +: DW];
      end
    end
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_any && owner == OW'(k)) begin
        m_gnt_o[k]           = 1'b1;
        m_data_o[k*DW +: DW] = rdata;
      end
    end
  end

  assign hold_flag_o = m_req_i[FETCH_M] & ~m_gnt_o[FETCH_M];

  // An owner drop takes precedence: preemption only matters while the owner still requests.
  assign preempt = others_req && (MAX_HOLD != 0) && (int'(cnt) >= MAX_HOLD - 1);

  always_comb begin
    own_vld_nxt = own_vld;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    if (own_vld) begin
      if (owner_req) begin
        if (preempt) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end else if (others_req) begin
        owner_nxt = pick;
        cnt_nxt   = '0;
      end else begin
        own_vld_nxt = 1'b0;
      end
    end else if (|m_req_i) begin
      own_vld_nxt = 1'b1;
      owner_nxt   = pick;
      cnt_nxt     = '0;
    end
  end

  // Stage 1: ownership state and registered error report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OW'(FETCH_M);
      own_vld    <= 1'b1;
      cnt        <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      owner   <= owner_nxt;
      own_vld <= own_vld_nxt;
      cnt     <= cnt_nxt;
      err_o   <= gnt_any & ~sel_ok;
      if (gnt_any && !sel_ok) err_addr_o <= g_addr;
    end
  end

endmodule

// File: tb/tb_rib_rr_xbar.sv
// Directed bench for rib_rr_xbar: reset owner, round-robin hold alternation,
// write routing, unmapped error pulse, owner-drop bubble and mid-transfer reset.
module tb_rib_rr_xbar;
  localparam int NM = 4;
  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_data_i;
  logic [NM*DW-1:0] m_data_o;
  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_gnt_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*DW-1:0] s_data_o;
  logic [NS*DW-1:0] s_data_i;
  logic [NS-1:0]    s_we_o;
  logic             hold_flag_o;
  logic             err_o;
  logic [AW-1:0]    err_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  rib_rr_xbar dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_addr_i   (m_addr_i),
    .m_data_i   (m_data_i),
    .m_data_o   (m_data_o),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_gnt_o    (m_gnt_o),
    .s_addr_o   (s_addr_o),
    .s_data_o   (s_data_o),
    .s_data_i   (s_data_i),
    .s_we_o     (s_we_o),
    .hold_flag_o(hold_flag_o),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_req_i[k]           = req;
    m_we_i[k]            = we;
    m_addr_i[k*AW +: AW] = addr;
    m_data_i[k*DW +: DW] = data;
  endtask

  initial begin
    rst_n    = 1'b0;
    m_req_i  = '0;
    m_we_i   = '0;
    m_addr_i = '0;
    m_data_i = '0;
    for (int s = 0; s < NS; s++) s_data_i[s*DW +: DW] = 32'hD000_0000 + 32'(s);
    step();
    step();
    chk("rst_err", err_o, 0);
    chk("rst_err_addr", err_addr_o, 0);

    // Fetch port granted in the first cycle after reset
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    chk("first_gnt", m_gnt_o, 4'b0010);
    chk("first_saddr0", s_addr_o[0*AW +: AW], 32'h10);
    chk("first_mdata1", m_data_o[1*DW +: DW], 32'hD000_0000);
    chk("first_mdata0", m_data_o[0*DW +: DW], 32'h0);
    chk("first_swe", s_we_o, 6'b0);
    chk("first_hold", hold_flag_o, 0);

    // Fresh reset, then m0 and m1 request continuously
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    for (int c = 0; c < 48; c++) begin
      #1;
      chk($sformatf("alt_gnt%0d", c), m_gnt_o, ((c / 16) % 2 == 0) ? 4'b0010 : 4'b0001);
      chk($sformatf("alt_hold%0d", c), hold_flag_o, (c / 16) % 2);
      step();
    end

    // m0 owns (cnt 0) and writes to slave 1
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b1, 32'h1000_0004, 32'hA5A5_A5A5);
    #1;
    chk("wr_gnt", m_gnt_o, 4'b0001);
    chk("wr_swe", s_we_o, 6'b000010);
    chk("wr_saddr1", s_addr_o[1*AW +: AW], 32'h4);
    chk("wr_sdata1", s_data_o[1*DW +: DW], 32'hA5A5_A5A5);
    chk("wr_saddr5", s_addr_o[5*AW +: AW], 32'h4);
    chk("wr_mdata0", m_data_o[0*DW +: DW], 32'hD000_0001);
    step();

    // m0 drops, m1 reads unmapped slave 7
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h7000_0000, 32'h0);
    #1;
    chk("um_bubble_gnt", m_gnt_o, 4'b0000);
    step();
    #1;
    chk("um_gnt", m_gnt_o, 4'b0010);
    chk("um_swe", s_we_o, 6'b0);
    chk("um_mdata1", m_data_o[1*DW +: DW], 32'h0);
    chk("um_err_early", err_o, 0);
    step();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("um_err", err_o, 1);
    chk("um_err_addr", err_addr_o, 32'h7000_0000);
    step();
    #1;
    chk("um_err_clear", err_o, 0);
    chk("um_err_addr_keep", err_addr_o, 32'h7000_0000);

    // Idle: one cycle of arbitration latency, then owner drop bubble
    drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    chk("idle_gnt", m_gnt_o, 4'b0000);
    step();
    drive(2, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    drive(3, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    #1;
    chk("drop_own_gnt", m_gnt_o, 4'b0010);
    step();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("drop_bubble", m_gnt_o, 4'b0000);
    step();
    #1;
    chk("drop_next", m_gnt_o, 4'b0100);
    step();

    // Hand over to m3 (unmapped address), then reset while m3 owns
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b1, 1'b0, 32'hF000_0000, 32'h0);
    #1;
    chk("m3_bubble", m_gnt_o, 4'b0000);
    step();
    #1;
    chk("m3_gnt", m_gnt_o, 4'b1000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_gnt", m_gnt_o, 4'b0000);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_hold", hold_flag_o, 0);
    step();
    #1;
    chk("regrant_m3", m_gnt_o, 4'b1000);
    step();
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("m3_err", err_o, 1);
    chk("m3_err_addr", err_addr_o, 32'hF000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
